// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester round-robin arbiter sharing one BRAM port, with bounded lock bursts
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic          last_grant;
    logic          locked;
    logic          owner;
    logic [BW-1:0] beats;
    logic          s1_pending;
    logic          s1_id;
    logic          s2_pending;
    logic          s2_id;

    logic                  owner_valid;
    logic                  lock_hold;
    logic                  accept;
    logic                  winner;
    logic                  win_we;
    logic                  win_lock;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [BW-1:0]         next_beats;

    always_comb begin
        owner_valid = owner ? req1_valid : req0_valid;
        lock_hold   = locked & owner_valid;
        accept      = reset_n & (req0_valid | req1_valid);
        if (lock_hold)
            winner = owner;
        else if (req0_valid && req1_valid)
            winner = ~last_grant;
        else
            winner = req1_valid;
        win_we     = winner ? req1_we    : req0_we;
        win_lock   = winner ? req1_lock  : req0_lock;
        win_addr   = winner ? req1_addr  : req0_addr;
        win_wdata  = winner ? req1_wdata : req0_wdata;
        // A beat by the current owner extends the burst; any other locking accept starts a new one.
        next_beats = lock_hold ? beats + BW'(1) : BW'(1);
    end

    assign req0_ready = accept & ~winner;
    assign req1_ready = accept & winner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= 1'b1;
            locked      <= 1'b0;
            owner       <= 1'b0;
            beats       <= '0;
            s1_pending  <= 1'b0;
            s1_id       <= 1'b0;
            s2_pending  <= 1'b0;
            s2_id       <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            s1_pending <= accept & ~win_we;
            s1_id      <= winner;
            s2_pending <= s1_pending;
            s2_id      <= s1_id;
            if (accept) begin
                last_grant  <= winner;
                mem_wr_en   <= win_we;
                mem_rd_en   <= ~win_we;
                mem_addr    <= win_addr;
                mem_wr_data <= win_wdata;
                // Reaching MAX_BURST forces release so the other requester gets the next turn.
                if (win_lock && (int'(next_beats) < MAX_BURST)) begin
                    locked <= 1'b1;
                    owner  <= winner;
                    beats  <= next_beats;
                end else begin
                    locked <= 1'b0;
                    beats  <= '0;
                end
            end else begin
                locked <= 1'b0;
                beats  <= '0;
            end
        end
    end

    assign rsp0_valid = s2_pending & ~s2_id;
    assign rsp1_valid = s2_pending & s2_id;
    assign rsp0_data  = mem_rd_data;
    assign rsp1_data  = mem_rd_data;
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester round-robin arbiter that shares one port of the dual-port BRAM (1-cycle registered read, write-enable/read-enable/address/write-data interface) between two independent masters, e.g. the ADC capture writer and the AXI readback engine. Each requester issues single-beat read or write commands over a valid/ready handshake, and read data is routed back to the originating requester. An optional lock allows bounded bursts: one requester keeps the port for up to MAX_BURST consecutive beats.

## Interface
- DATA_WIDTH, 8, BRAM word width
- ADDR_WIDTH, 10, BRAM address width
- MAX_BURST, 16, maximum consecutive locked beats per grant (≥1); burst counter width is $clog2(MAX_BURST+1)
- clk  in  1  single clock for arbiter and attached BRAM port
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  command valid
- req0_ready / req1_ready  out  1  command accepted this cycle when valid&ready
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_lock / req1_lock  in  1  request to keep the grant after this beat
- req0_addr / req1_addr  in  ADDR_WIDTH  word address
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse, read data valid
- rsp0_data / rsp1_data  out  DATA_WIDTH  read data (both carry mem_rd_data; qualify with rspN_valid)
- mem_wr_en  out  1  to BRAM port wr_en, registered
- mem_rd_en  out  1  to BRAM port rd_en, registered
- mem_addr  out  ADDR_WIDTH  to BRAM port addr, registered
- mem_wr_data  out  DATA_WIDTH  to BRAM port wr_data, registered
- mem_rd_data  in  DATA_WIDTH  from BRAM port rd_data

## Operation
- Winner selection (combinational, every cycle):
  - If locked and owner's valid=1, the winner is the owner.
  - Otherwise, if both are valid, the winner is the requester that is not last_grant.
  - Otherwise, the winner is whichever is valid; if neither is valid, there is no winner.
- reqN_ready = (winner==N). Ready may depend on both valids, so requesters must not make valid depend on ready.
- On accept: last_grant <= winner. The registered mem_* outputs take the command: wr_en=we, rd_en=~we, addr, wr_data.
- Idle cycle (no accept): mem_wr_en=0, mem_rd_en=0. mem_addr and mem_wr_data hold their last values.
- Lock/burst counter (beats):
  - Accept with lock=1 while unlocked: locked <= 1, owner <= winner, beats <= 1.
  - Accept by owner with lock=1: beats increments.
  - When beats would reach MAX_BURST, locked <= 0 and beats <= 0, even if lock=1. The next arbitration is normal round-robin, so the other requester wins if valid.
  - Accept with lock=0: locked <= 0, beats <= 0.
  - Owner's valid=0 while locked: locked <= 0, beats <= 0 that cycle, and normal arbitration applies in that same cycle.
- Read response tracking: a 2-stage tag pipeline (pending, id) tracks reads.
  - Stage 1 aligns with the mem_rd_en cycle; stage 2 aligns with the cycle the BRAM presents data.
  - rspN_valid = stage2.pending & (stage2.id==N).
- Writes produce no response.
- Reads and writes from both requesters may interleave back-to-back. The BRAM port provides read-old/write ordering per address in command order.

## Timing
- Throughput: one accepted command per clock, sustained.
- Read latency: accept at edge T. mem_rd_en is high during cycle T+1. BRAM data is valid during T+2, so rspN_valid is high for exactly one cycle at T+2.
- Write: mem_wr_en is high during T+1, and the memory is updated at the end of T+1. A read accepted at T+1 to the same address returns the new data.
- Reset (reset_n=0, asynchronous):
  - mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wr_data=0.
  - rsp0_valid=rsp1_valid=0; all tag pipeline bits cleared.
  - locked=0, beats=0, last_grant=1, so req0 wins the first contention.
  - req ready outputs are 0 while reset_n=0.
- Reads in flight when reset asserts are dropped; no rsp_valid is issued for them after release.
- Reset release is synchronized by the parent. The first accept can occur on the first edge with reset_n=1.

## Test plan
- Reset, then req0 read addr 0x005 (BRAM preloaded 0x5A) -> req0_ready=1 that cycle; mem_rd_en=1 at T+1; rsp0_valid=1 and rsp0_data=0x5A at T+2; rsp1_valid stays 0.
- Both valid continuously, no lock, with req0 writing addrs 0..3 and req1 reading addr 0x100 -> grants alternate 0,1,0,1 starting with req0; mem_wr_en/mem_rd_en alternate each cycle; req1 gets 2 responses, 2 cycles after each of its accepts.
- req0 asserts lock on every beat with MAX_BURST=4 while req1 is valid -> req0 wins exactly 4 consecutive beats, then req1 wins, then req0 resumes its lock cycle.
- req1 is locked and drops valid mid-burst after 2 beats while req0 is valid -> req0 is granted in the same cycle; locked and beats are cleared.
- req1 writes 0xC3 to addr 0x010 at T, and req0 reads addr 0x010 at T+1 -> rsp0_data=0xC3 at T+3.
- Issue 3 back-to-back reads, then pull reset_n low for 1 cycle after the 2nd accept -> all mem_* and rsp outputs are 0 immediately; no rsp_valid appears after release; the first post-reset contention is granted to req0.
